// File: rtl/color_classifier_if.sv
// Signal bundle between the colour sensor / host side and color_classifier.
interface color_classifier_if;
    logic       frequency;
    logic       cal_start;
    logic [1:0] filter_out;
    logic [1:0] frequency_rate;
    logic       led;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       frame_valid;
    logic       cal_done;
    logic       is_move;
    logic [1:0] move;

    modport master (
        output frequency, cal_start,
        input  filter_out, frequency_rate, led, red, green, blue,
        input  frame_valid, cal_done, is_move, move
    );

    modport slave (
        input  frequency, cal_start,
        output filter_out, frequency_rate, led, red, green, blue,
        output frame_valid, cal_done, is_move, move
    );
endinterface

// File: rtl/color_classifier.sv
// Frequency-counting colour classifier with white-balance calibration.
// Optional output debounce is enabled by defining COLOR_DEBOUNCE_EN.
module color_classifier #(
    parameter int WIN_CYCLES = 100000,
    parameter int SETTLE_CYC = 1000,
    parameter int CNT_W      = 16,
    parameter int DARK_TH    = 100,
    parameter int BRIGHT_TH  = 180,
    parameter int STABLE_N   = 3
) (
    input logic               clk,
    input logic               rst,
    color_classifier_if.slave bus
);
    localparam int DW   = CNT_W + 8;
    localparam int M1   = (WIN_CYCLES > SETTLE_CYC) ? WIN_CYCLES : SETTLE_CYC;
    localparam int TMAX = (M1 > DW) ? M1 : DW;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [7:0] DARK   = 8'(DARK_TH);
    localparam logic [7:0] BRIGHT = 8'(BRIGHT_TH);

    typedef enum logic [2:0] {
        CAL_SETTLE, CAL_COUNT, RUN_SETTLE, RUN_COUNT, DIV, CLASSIFY
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             ch_q, ch_d, filt_q, filt_d;
    logic [1:0]             sync_q, sync_d, mv_q, mv_d;
    logic                   prev_q, prev_d, fv_q, fv_d;
    logic                   done_q, done_d, ism_q, ism_d;
    logic [TW-1:0]          tmr_q, tmr_d, lim;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc, rem_q, rem_d, wref;
    logic [2:0][CNT_W-1:0]  white_q, white_d;
    logic [DW-1:0]          dvd_q, dvd_d, quo;
    logic [2:0][7:0]        val_q, val_d;
    logic [7:0]             red_q, red_d, grn_q, grn_d, blu_q, blu_d, quo_sat;
    logic [CNT_W:0]         trial;
    logic                   ge, tlast, cand_ok;
    logic [2:0]             cand;

`ifdef COLOR_DEBOUNCE_EN
    localparam int AW = $clog2(STABLE_N + 1);
    localparam logic [AW-1:0] NEED = AW'(STABLE_N);
    logic [2:0]    dcand_q, dcand_d;
    logic [AW-1:0] agree_q, agree_d, agree_n;
`endif

    // Datapath: edge counter, one restoring-divider step, phase timer limit.
    always_comb begin
        wref = white_q[0];
        for (int i = 1; i < 3; i++)
            if (ch_q == 2'(i)) wref = white_q[i];
        cnt_inc = cnt_q;
        if (sync_q[1] && !prev_q && cnt_q != '1)
            cnt_inc = cnt_q + CNT_W'(1);
        trial   = {rem_q, dvd_q[DW-1]};
        ge      = trial >= {1'b0, wref};
        quo     = {dvd_q[DW-2:0], ge};
        quo_sat = (|quo[DW-1:8]) ? 8'hff : quo[7:0];
        case (state_q)
            CAL_SETTLE, RUN_SETTLE: lim = TW'(SETTLE_CYC - 1);
            CAL_COUNT, RUN_COUNT:   lim = TW'(WIN_CYCLES - 1);
            default:                lim = TW'(DW - 1);
        endcase
        tlast = tmr_q == lim;
    end

    // Candidate encoded as {is_move, move}; cand_ok low on a tie.
    always_comb begin
        cand_ok = 1'b1;
        cand    = 3'b000;
        if (val_q[0] < DARK && val_q[1] < DARK && val_q[2] < DARK)
            cand = 3'b111;
        else if (val_q[0] > BRIGHT && val_q[1] > BRIGHT && val_q[2] > BRIGHT)
            cand = 3'b000;
        else if (val_q[0] > val_q[1] && val_q[0] > val_q[2])
            cand = 3'b100;
        else if (val_q[1] > val_q[0] && val_q[1] > val_q[2])
            cand = 3'b101;
        else if (val_q[2] > val_q[0] && val_q[2] > val_q[1])
            cand = 3'b110;
        else
            cand_ok = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        white_d = white_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        val_d   = val_q;
        red_d   = red_q;
        grn_d   = grn_q;
        blu_d   = blu_q;
        mv_d    = mv_q;
        ism_d   = ism_q;
        done_d  = done_q;
        fv_d    = 1'b0;
        sync_d  = {sync_q[0], bus.frequency};
        prev_d  = sync_q[1];
`ifdef COLOR_DEBOUNCE_EN
        dcand_d = dcand_q;
        agree_d = agree_q;
        agree_n = agree_q;
`endif
        if (bus.cal_start) begin
            state_d = CAL_SETTLE;
            ch_d    = 2'd0;
            tmr_d   = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else begin
            tmr_d = tlast ? '0 : tmr_q + TW'(1);
            unique case (state_q)
                CAL_SETTLE, RUN_SETTLE: begin
                    cnt_d = '0;
                    if (tlast)
                        state_d = (state_q == CAL_SETTLE) ? CAL_COUNT : RUN_COUNT;
                end
                CAL_COUNT: begin
                    cnt_d = cnt_inc;
                    if (tlast) begin
                        cnt_d = '0;
                        for (int i = 0; i < 3; i++)
                            if (ch_q == 2'(i))
                                white_d[i] = (cnt_inc == '0) ? CNT_W'(1) : cnt_inc;
                        if (ch_q == 2'd2) begin
                            ch_d    = 2'd0;
                            done_d  = 1'b1;
                            state_d = RUN_SETTLE;
                        end else begin
                            ch_d    = ch_q + 2'd1;
                            state_d = CAL_SETTLE;
                        end
                    end
                end
                RUN_COUNT: begin
                    cnt_d = cnt_inc;
                    if (tlast) begin
                        cnt_d   = '0;
                        dvd_d   = {cnt_inc, 8'd0};
                        rem_d   = '0;
                        state_d = DIV;
                    end
                end
                DIV: begin
                    dvd_d = quo;
                    rem_d = ge ? trial[CNT_W-1:0] - wref : trial[CNT_W-1:0];
                    if (tlast) begin
                        for (int i = 0; i < 3; i++)
                            if (ch_q == 2'(i)) val_d[i] = quo_sat;
                        if (ch_q == 2'd2) begin
                            state_d = CLASSIFY;
                        end else begin
                            ch_d    = ch_q + 2'd1;
                            state_d = RUN_SETTLE;
                        end
                    end
                end
                CLASSIFY: begin
                    tmr_d   = '0;
                    red_d   = val_q[0];
                    grn_d   = val_q[1];
                    blu_d   = val_q[2];
                    fv_d    = 1'b1;
                    ch_d    = 2'd0;
                    state_d = RUN_SETTLE;
`ifdef COLOR_DEBOUNCE_EN
                    if (!cand_ok) begin
                        agree_d = '0;
                    end else begin
                        if (agree_q != '0 && cand == dcand_q)
                            agree_n = (agree_q >= NEED) ? agree_q : agree_q + AW'(1);
                        else
                            agree_n = AW'(1);
                        dcand_d = cand;
                        agree_d = agree_n;
                        if (agree_n >= NEED) {ism_d, mv_d} = cand;
                    end
`else
                    if (cand_ok) {ism_d, mv_d} = cand;
`endif
                end
                default: begin
                    state_d = CAL_SETTLE;
                    ch_d    = 2'd0;
                    tmr_d   = '0;
                end
            endcase
        end
        unique case (ch_d)
            2'd1:    filt_d = 2'b11;
            2'd2:    filt_d = 2'b01;
            default: filt_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CAL_SETTLE;
            ch_q    <= 2'd0;
            filt_q  <= 2'b00;
            sync_q  <= 2'b00;
            prev_q  <= 1'b0;
            tmr_q   <= '0;
            cnt_q   <= '0;
            white_q <= {3{CNT_W'(1)}};
            dvd_q   <= '0;
            rem_q   <= '0;
            val_q   <= '0;
            red_q   <= 8'd0;
            grn_q   <= 8'd0;
            blu_q   <= 8'd0;
            mv_q    <= 2'b00;
            ism_q   <= 1'b0;
            done_q  <= 1'b0;
            fv_q    <= 1'b0;
`ifdef COLOR_DEBOUNCE_EN
            dcand_q <= 3'b000;
            agree_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            filt_q  <= filt_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            white_q <= white_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            val_q   <= val_d;
            red_q   <= red_d;
            grn_q   <= grn_d;
            blu_q   <= blu_d;
            mv_q    <= mv_d;
            ism_q   <= ism_d;
            done_q  <= done_d;
            fv_q    <= fv_d;
`ifdef COLOR_DEBOUNCE_EN
            dcand_q <= dcand_d;
            agree_q <= agree_d;
`endif
        end
    end

    assign bus.filter_out     = filt_q;
    assign bus.frequency_rate = 2'b01;
    assign bus.led            = 1'b1;
    assign bus.red            = red_q;
    assign bus.green          = grn_q;
    assign bus.blue           = blu_q;
    assign bus.frame_valid    = fv_q;
    assign bus.cal_done       = done_q;
    assign bus.is_move        = ism_q;
    assign bus.move           = mv_q;
endmodule

// File: doc/color_classifier.md
COLOR_CLASSIFIER -- requirements
Module: color_classifier

Interface
REQ-001 Parameter WIN_CYCLES, default 100000: clock cycles per channel counting window.
REQ-002 Parameter SETTLE_CYC, default 1000: clock cycles per channel after a filter switch during which edges are ignored.
REQ-003 Parameter CNT_W, default 16: edge-counter width.
REQ-004 Parameter DARK_TH, default 100, and parameter BRIGHT_TH, default 180: 8-bit black and white thresholds.
REQ-005 Parameter STABLE_N, default 3: number of consecutive identical frames required by the debounce.
REQ-006 Port list, one port per line (name  direction  width  meaning):
- clk  in  1  system clock; the block has one clock.
- rst  in  1  reset; asynchronous, active-high.
- frequency  in  1  sensor output; asynchronous to clk.
- cal_start  in  1  one-cycle pulse that requests white-balance recalibration.
- filter_out  out  2  sensor S3,S2 select: red 00, blue 01, green 11.
- frequency_rate  out  2  sensor scaling; constant 01.
- led  out  1  illumination; constant 1.
- red, green, blue  out  8 each  normalised channel values from the last frame.
- frame_valid  out  1  one-cycle pulse when the normalised values update.
- cal_done  out  1  high once white references are loaded.
- is_move  out  1  movement enable.
- move  out  2  direction code.

Function
REQ-007 frequency SHALL pass through a 2-flop synchroniser, and the counter SHALL count each synchronised rising edge.
REQ-008 The per-channel sequence SHALL be SETTLE (exactly SETTLE_CYC cycles, no counting), then COUNT (exactly WIN_CYCLES cycles), then, in run mode only, DIV (exactly CNT_W+8 cycles).
REQ-009 The channel order SHALL be red, then green, then blue.
REQ-010 filter_out SHALL show the current channel in every state.
REQ-011 The edge counter SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-012 The FSM states SHALL be CAL_SETTLE, CAL_COUNT, RUN_SETTLE, RUN_COUNT, DIV and CLASSIFY.
REQ-013 After reset the FSM SHALL enter CAL_SETTLE on red.
REQ-014 After the blue calibration count the FSM SHALL set cal_done and go to RUN_SETTLE on red.
REQ-015 Calibration SHALL store each count as that channel's white reference; a count of 0 SHALL be stored as 1.
REQ-016 DIV SHALL compute floor(count*256/white_ref) with a sequential restoring divider, saturated to 255.
REQ-017 After blue DIV the FSM SHALL spend one CLASSIFY cycle, then return to RUN_SETTLE on red.
REQ-018 In CLASSIFY, red, green and blue SHALL update and frame_valid SHALL pulse in the same cycle.
REQ-019 Each frame SHALL be classified in priority order:
- black if all three values < DARK_TH: move 11, is_move 1;
- white if all three values > BRIGHT_TH: move 00, is_move 0;
- red strictly largest: move 00, is_move 1;
- green strictly largest: move 01, is_move 1;
- blue strictly largest: move 10, is_move 1;
- otherwise (tie for maximum): no candidate, outputs hold.
REQ-020 The run frame period SHALL be 3*(SETTLE_CYC+WIN_CYCLES+CNT_W+8)+1 cycles.
REQ-021 A cal_start pulse in any state SHALL, at the next edge:
- abort the current measurement;
- clear cal_done;
- enter CAL_SETTLE on red;
- hold is_move and move.
REQ-022 cal_start asserted during calibration SHALL restart calibration from red.
REQ-023 No frame_valid pulse SHALL occur while cal_done is 0.

Reset
REQ-024 On rst, the following SHALL clear immediately, independent of clk:
- is_move, move, red, green, blue, frame_valid, cal_done: 0;
- filter_out: 00;
- counters, debounce state and synchroniser flops: 0;
- white references: 1.
REQ-025 Reset asserted mid-operation SHALL discard all partial counts, and the block SHALL restart calibration on the first clock after release.

Configuration
REQ-026 The macro COLOR_DEBOUNCE_EN SHALL control output debounce.
REQ-027 With COLOR_DEBOUNCE_EN defined:
- move and is_move SHALL update only after STABLE_N consecutive frames yield the same candidate;
- a tie frame SHALL reset the agreement count.
REQ-028 Without COLOR_DEBOUNCE_EN, move and is_move SHALL update in every CLASSIFY cycle with a non-tie candidate.

Verification (WIN_CYCLES=100, SETTLE_CYC=4, CNT_W=8, STABLE_N=2, debounce enabled)
REQ-029 Calibration: square wave, period 4 clocks, on all channels after reset -> cal_done rises 312 cycles after reset release; white references are all 25.
REQ-030 Red frame: edge counts red 25, green 5, blue 5 -> values 255/51/51, frame period 361 cycles; after 2 frames move=00, is_move=1; after 1 frame outputs still hold.
REQ-031 Black and white: counts 5/5/5 -> values 51/51/51, move=11, is_move=1; then counts 25/25/25 -> values 255/255/255, is_move=0, move=00.
REQ-032 Tie: counts 20/20/10 -> values 204/204/102, frame_valid pulses, move and is_move unchanged.
REQ-033 Disruption: rst pulse during green RUN_COUNT -> all outputs 0 immediately, then recalibration; cal_start during RUN_COUNT -> cal_done=0 next cycle, filter_out=00, move held.
